// File: rtl/axi_block_read_master.sv
// AXI4 read-burst master that refills one cache block. It issues a single INCR
// burst and assembles the returned beats into a flat block buffer.
module axi_block_read_master #(
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WORDS = 16
) (
  input  logic                              clk,
  input  logic                              arstn,
  input  logic                              i_start_read,
  input  logic [ADDR_WIDTH-1:0]             i_addr,
  output logic                              o_read_last,
  output logic                              o_read_error,
  output logic                              o_busy,
  output logic [DATA_WIDTH*BLOCK_WORDS-1:0] o_data_block,
  output logic [ADDR_WIDTH-1:0]             o_araddr,
  output logic [7:0]                        o_arlen,
  output logic [2:0]                        o_arsize,
  output logic [1:0]                        o_arburst,
  output logic                              o_arvalid,
  input  logic                              i_arready,
  input  logic [DATA_WIDTH-1:0]             i_rdata,
  input  logic [1:0]                        i_rresp,
  input  logic                              i_rlast,
  input  logic                              i_rvalid,
  output logic                              o_rready
);

  localparam int OFFSET_BITS = $clog2(BLOCK_WORDS * DATA_WIDTH / 8);
  localparam int CNT_W       = $clog2(BLOCK_WORDS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] beat_cnt;
  logic             at_last;

  assign o_arlen   = 8'(BLOCK_WORDS - 1);
  assign o_arsize  = 3'($clog2(DATA_WIDTH / 8));
  assign o_arburst = 2'b01;

  assign at_last = (beat_cnt == LAST_BEAT);

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state        <= IDLE;
      beat_cnt     <= '0;
      o_araddr     <= '0;
      o_arvalid    <= 1'b0;
      o_rready     <= 1'b0;
      o_read_last  <= 1'b0;
      o_read_error <= 1'b0;
      o_busy       <= 1'b0;
      // NOTE: the block buffer lives in flops rather than a RAM macro, so it
      // can be reset and o_data_block is never X after reset.
      o_data_block <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start_read) begin
            o_araddr     <= {i_addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            beat_cnt     <= '0;
            o_read_error <= 1'b0;
            o_arvalid    <= 1'b1;
            o_busy       <= 1'b1;
            state        <= ADDR;
          end
        end
        ADDR: begin
          // arvalid is raised unconditionally on entry; only its drop waits on arready.
          if (o_arvalid && i_arready) begin
            o_arvalid <= 1'b0;
            o_rready  <= 1'b1;
            state     <= DATA;
          end
        end
        DATA: begin
          if (i_rvalid && o_rready) begin
            o_data_block[int'(beat_cnt) * DATA_WIDTH +: DATA_WIDTH] <= i_rdata;
            beat_cnt <= beat_cnt + CNT_W'(1);
            // Slave error, or rlast disagreeing with our own beat count.
            if ((i_rresp != 2'b00) || (i_rlast != at_last)) begin
              o_read_error <= 1'b1;
            end
            if (i_rlast || at_last) begin
              o_rready    <= 1'b0;
              o_read_last <= 1'b1;
              state       <= DONE;
            end
          end
        end
        DONE: begin
          o_read_last <= 1'b0;
          o_busy      <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_block_read_master.sv
// Directed bench for axi_block_read_master: the bench acts as AXI slave, queues
// expected block words as beats are driven and compares them when the block completes.
module tb_axi_block_read_master;

  localparam int AW = 64;
  localparam int DW = 32;
  localparam int BW = 16;
  localparam logic [AW-1:0] OFFSET_MASK = 64'h3F;

  logic              clk = 1'b0;
  logic              arstn;
  logic              i_start_read;
  logic [AW-1:0]     i_addr;
  logic              o_read_last;
  logic              o_read_error;
  logic              o_busy;
  logic [DW*BW-1:0]  o_data_block;
  logic [AW-1:0]     o_araddr;
  logic [7:0]        o_arlen;
  logic [2:0]        o_arsize;
  logic [1:0]        o_arburst;
  logic              o_arvalid;
  logic              i_arready;
  logic [DW-1:0]     i_rdata;
  logic [1:0]        i_rresp;
  logic              i_rlast;
  logic              i_rvalid;
  logic              o_rready;

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int rl_count = 0;
  int exp_rl   = 0;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_q[$];

  axi_block_read_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_WORDS(BW)) dut (
    .clk(clk), .arstn(arstn), .i_start_read(i_start_read), .i_addr(i_addr),
    .o_read_last(o_read_last), .o_read_error(o_read_error), .o_busy(o_busy),
    .o_data_block(o_data_block), .o_araddr(o_araddr), .o_arlen(o_arlen),
    .o_arsize(o_arsize), .o_arburst(o_arburst), .o_arvalid(o_arvalid),
    .i_arready(i_arready), .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rlast(i_rlast),
    .i_rvalid(i_rvalid), .o_rready(o_rready)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_read_last === 1'b1) rl_count++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "simulation timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Request a block and walk the AR phase, holding arready low for ar_stall cycles.
  task automatic start_burst(input logic [AW-1:0] addr, input int ar_stall);
    i_start_read = 1'b1;
    i_addr       = addr;
    i_arready    = (ar_stall == 0);
    exp_addr     = addr & ~OFFSET_MASK;
    cyc          = 0;
    tick();
    i_start_read = 1'b0;
    i_addr       = ~addr;
    check("addr_err_cleared", 64'(o_read_error), 64'd0);
    for (int s = 0; s < ar_stall; s++) begin
      check("stall_arvalid", 64'(o_arvalid), 64'd1);
      check("stall_araddr", o_araddr, exp_addr);
      check("stall_rready", 64'(o_rready), 64'd0);
      tick();
    end
    i_arready = 1'b1;
    check("addr_arvalid", 64'(o_arvalid), 64'd1);
    check("addr_araddr", o_araddr, exp_addr);
    check("addr_busy", 64'(o_busy), 64'd1);
    check("addr_rready", 64'(o_rready), 64'd0);
    tick();
    check("data_arvalid", 64'(o_arvalid), 64'd0);
    check("data_rready", 64'(o_rready), 64'd1);
  endtask

  // Drive n R beats; expected words are queued as each beat is presented.
  task automatic send_beats(input int n, input int last_at, input int err_at,
                            input bit toggle, input int pulse_at, input logic [DW-1:0] base);
    for (int k = 0; k < n; k++) begin
      if (toggle && k > 0) begin
        i_rvalid = 1'b0;
        i_rlast  = 1'b0;
        i_rresp  = 2'b00;
        check("gap_read_last", 64'(o_read_last), 64'd0);
        tick();
      end
      i_rvalid     = 1'b1;
      i_rdata      = base + DW'(k);
      i_rlast      = (k == last_at);
      i_rresp      = (k == err_at) ? 2'b10 : 2'b00;
      i_start_read = (k == pulse_at);
      i_addr       = (k == pulse_at) ? 64'hDEAD_0000 : i_addr;
      check($sformatf("beat%0d_rready", k), 64'(o_rready), 64'd1);
      check($sformatf("beat%0d_read_last", k), 64'(o_read_last), 64'd0);
      exp_q.push_back(base + DW'(k));
      tick();
    end
    i_rvalid     = 1'b0;
    i_rlast      = 1'b0;
    i_rresp      = 2'b00;
    i_start_read = 1'b0;
  endtask

  // Called in the cycle after the final beat: DONE checks plus scoreboard drain.
  task automatic finish_burst(input bit exp_err);
    int k;
    logic [DW-1:0] w;
    check("done_read_last", 64'(o_read_last), 64'd1);
    check("done_rready", 64'(o_rready), 64'd0);
    check("done_busy", 64'(o_busy), 64'd1);
    check("done_error", 64'(o_read_error), 64'(exp_err));
    check("done_araddr", o_araddr, exp_addr);
    k = 0;
    while (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      check($sformatf("word%0d", k), 64'(o_data_block[k*DW +: DW]), 64'(w));
      k++;
    end
    exp_rl++;
    tick();
    check("idle_read_last", 64'(o_read_last), 64'd0);
    check("idle_busy", 64'(o_busy), 64'd0);
    check("idle_error", 64'(o_read_error), 64'(exp_err));
    check("read_last_pulses", 64'(rl_count), 64'(exp_rl));
  endtask

  initial begin
    arstn        = 1'b0;
    i_start_read = 1'b0;
    i_addr       = '0;
    i_arready    = 1'b0;
    i_rdata      = '0;
    i_rresp      = 2'b00;
    i_rlast      = 1'b0;
    i_rvalid     = 1'b0;
    #3;
    check("rst_arvalid", 64'(o_arvalid), 64'd0);
    check("rst_rready", 64'(o_rready), 64'd0);
    check("rst_read_last", 64'(o_read_last), 64'd0);
    check("rst_error", 64'(o_read_error), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_araddr", o_araddr, 64'd0);
    check("rst_block", 64'(o_data_block === '0), 64'd1);
    check("arlen", 64'(o_arlen), 64'd15);
    check("arsize", 64'(o_arsize), 64'd2);
    check("arburst", 64'(o_arburst), 64'd1);
    @(negedge clk);
    arstn = 1'b1;
    tick();
    tick();

    // Clean burst, no backpressure: read_last lands in cycle 18 after start.
    start_burst(64'h0000_1234, 0);
    check("araddr_aligned", o_araddr, 64'h1200);
    send_beats(16, 15, -1, 1'b0, -1, 32'hA0);
    check("latency_cycle", 64'(cyc), 64'd18);
    finish_burst(1'b0);

    // AR backpressure for three cycles.
    start_burst(64'h0000_5678, 3);
    send_beats(16, 15, -1, 1'b0, -1, 32'h1000);
    finish_burst(1'b0);

    // rvalid toggling every cycle.
    start_burst(64'h0000_9ABC, 0);
    send_beats(16, 15, -1, 1'b1, -1, 32'h2000);
    finish_burst(1'b0);

    // SLVERR on beat 7: error sticks through IDLE until the next start.
    start_burst(64'h0001_0000, 0);
    send_beats(16, 15, 7, 1'b0, -1, 32'h3000);
    finish_burst(1'b1);
    tick();
    tick();
    check("error_sticky_idle", 64'(o_read_error), 64'd1);

    // Early rlast on beat 5: six beats, then DONE with error.
    start_burst(64'h0002_0040, 0);
    send_beats(6, 5, -1, 1'b0, -1, 32'h4000);
    finish_burst(1'b1);

    // Asynchronous reset while beat 9 is on the bus.
    start_burst(64'h0003_0080, 0);
    send_beats(9, 15, -1, 1'b0, -1, 32'h5000);
    i_rvalid = 1'b1;
    i_rdata  = 32'h5009;
    #2;
    arstn = 1'b0;
    #1;
    check("midrst_arvalid", 64'(o_arvalid), 64'd0);
    check("midrst_rready", 64'(o_rready), 64'd0);
    check("midrst_busy", 64'(o_busy), 64'd0);
    check("midrst_read_last", 64'(o_read_last), 64'd0);
    check("midrst_error", 64'(o_read_error), 64'd0);
    check("midrst_araddr", o_araddr, 64'd0);
    check("midrst_block", 64'(o_data_block === '0), 64'd1);
    exp_q.delete();
    i_rvalid = 1'b0;
    @(negedge clk);
    arstn = 1'b1;
    tick();
    check("postrst_busy", 64'(o_busy), 64'd0);
    start_burst(64'h0004_00C7, 0);
    send_beats(16, 15, -1, 1'b0, -1, 32'h6000);
    finish_burst(1'b0);

    // start pulsed mid-DATA with another address must be ignored.
    start_burst(64'h0005_0100, 0);
    send_beats(16, 15, -1, 1'b0, 4, 32'h7000);
    finish_burst(1'b0);
    tick();
    tick();
    check("no_requeue_busy", 64'(o_busy), 64'd0);
    check("no_requeue_pulses", 64'(rl_count), 64'(exp_rl));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_block_read_master.md
Name: axi_block_read_master

Overview:
- AXI4 read-burst master that services cache block refills for the instruction and data cache FSMs.
- Takes the control unit's combined read-start request and a block address, then issues one INCR burst on AR.
- Collects the R beats into a full cache-block buffer.
- Signals completion with a one-cycle read-last pulse, which is the r_last input consumed by both cache FSMs.

Parameters:
- ADDR_WIDTH, 64, byte address width of AR channel and request address.
- DATA_WIDTH, 32, R channel data width in bits (power of two, >= 8).
- BLOCK_WORDS, 16, DATA_WIDTH-sized beats per cache block (power of two, 2..256).

Ports:
- clk  in  1  system clock.
- arstn  in  1  asynchronous active-low reset.
- i_start_read  in  1  refill request (level); sampled only in IDLE.
- i_addr  in  ADDR_WIDTH  miss address; low bits are dropped to block alignment.
- o_read_last  out  1  one-cycle pulse: block buffer complete.
- o_read_error  out  1  sticky error flag for the current/last burst.
- o_busy  out  1  high in any state other than IDLE.
- o_data_block  out  DATA_WIDTH*BLOCK_WORDS  assembled block; word k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- o_araddr  out  ADDR_WIDTH  burst start address.
- o_arlen  out  8  equals BLOCK_WORDS-1.
- o_arsize  out  3  equals log2(DATA_WIDTH/8).
- o_arburst  out  2  constant 2'b01 (INCR).
- o_arvalid  out  1  AR valid.
- i_arready  in  1  AR ready.
- i_rdata  in  DATA_WIDTH  read data.
- i_rresp  in  2  read response.
- i_rlast  in  1  last beat marker.
- i_rvalid  in  1  R valid.
- o_rready  out  1  R ready.

Behaviour:
- Reset (arstn low, asynchronous): state IDLE; o_arvalid, o_rready, o_read_last, o_read_error, o_busy = 0; o_araddr = 0; beat counter = 0; o_data_block = 0.
- o_arlen, o_arsize and o_arburst are constants regardless of state.
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE:
  - If i_start_read is high: latch o_araddr = i_addr with the low log2(BLOCK_WORDS*DATA_WIDTH/8) bits forced to 0.
  - Clear counter and o_read_error; go to ADDR.
- ADDR:
  - o_arvalid = 1; o_araddr held stable.
  - On i_arready & o_arvalid, go to DATA. o_arvalid drops next cycle.
  - No dependence of o_arvalid on i_arready (AXI rule).
- DATA:
  - o_rready = 1.
  - Each cycle with i_rvalid & o_rready: write i_rdata into block word [counter], then increment counter.
  - If i_rresp != 2'b00, set o_read_error.
  - Accepted beat where i_rlast=1 OR counter==BLOCK_WORDS-1 → go to DONE.
  - Mismatch (i_rlast=1 with counter != BLOCK_WORDS-1, or counter==BLOCK_WORDS-1 with i_rlast=0): set o_read_error and still go to DONE.
  - Beats with i_rvalid low are ignored; any gap length is allowed.
- DONE:
  - o_read_last = 1 for exactly one cycle; o_rready = 0; then go to IDLE.
  - o_data_block is stable and complete throughout DONE and held until the next accepted beat of a later burst.
- Latency, no backpressure (arready high, rvalid continuous): start sampled at edge 0; arvalid high cycle 1; first beat accepted cycle 2; last beat cycle BLOCK_WORDS+1; o_read_last high cycle BLOCK_WORDS+2.
- i_start_read in ADDR/DATA/DONE is ignored; no queuing.
  - The requester must drop start the cycle after o_read_last, as the cache FSMs do.
  - If start is still high in the first IDLE cycle after DONE, a new burst begins (legal).
- i_addr is only sampled at the IDLE→ADDR transition; later changes have no effect.
- Counter width is log2(BLOCK_WORDS); it never wraps within a burst because DONE is forced at BLOCK_WORDS-1.
- o_read_error persists through IDLE until the next start is accepted.
- Reset mid-burst returns immediately to IDLE with outputs at reset values. Outstanding AXI beats are not drained; the interconnect is reset in the same domain.

Test Plan:
- BLOCK_WORDS=16, i_addr=0x0000_1234, arready=1, rvalid continuous with data 0xA0+k, rlast on beat 15 → o_araddr=0x1200, arlen=15, arsize=2, arburst=1; o_read_last in cycle 18 after start; word k=0xA0+k; o_read_error=0.
- i_arready held low 3 cycles → o_arvalid high 4 cycles with o_araddr constant; no rready before handshake; block correct.
- rvalid toggling 1/0 every cycle across 16 beats → 16 words stored in order; o_read_last once, 1 cycle after beat 15.
- rresp=2'b10 on beat 7 → o_read_error=1 at DONE and in IDLE; cleared on next accepted start. Separately, rlast on beat 5 → DONE after 6 beats, o_read_error=1.
- arstn low during beat 9 → outputs zeroed asynchronously; new start after release runs a full clean burst.
- i_start_read pulsed during DATA with a different address → ignored; o_araddr unchanged; only one o_read_last.
